// File: rtl/axi4b_pkg.sv
// Shared AXI4 B-channel types: response codes and the queued {id, resp} entry.
// Entry id is sized for the widest supported ID; narrower IDs are zero-extended.
package axi4b_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    localparam int ID_MAX_W = 8;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        resp_e               resp;
    } b_entry_t;

    function automatic logic resp_is_err(input logic [1:0] r);
        return r[1];
    endfunction

endpackage

// File: rtl/axi4b_if.sv
// AXI4 write-response (B) channel; the slave drives bid/bresp/bvalid, the master drives bready.
interface axi4b_if #(
    parameter int ID_W = 1
) ();
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (input bid, input bresp, input bvalid, output bready);
    modport slave  (output bid, output bresp, output bvalid, input bready);
endinterface

// File: rtl/axi4b_resp_fifo.sv
// N-entry FIFO with pointers wrapping modulo N (N need not be a power of two).
// Head is read combinationally; caller guarantees no push when full and no pop when empty.
module axi4b_resp_fifo #(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    logic [W-1:0]  mem_q [N];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= bump(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= bump(rd_ptr_q);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/axi4b_resp_gen.sv
// B-response generator: output register plus (DEPTH-1)-deep queue, strict FIFO order, 1-cycle latency.
// done_ready is registered from the next count, so a pop while full frees a slot only on the following cycle.
module axi4b_resp_gen
    import axi4b_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done_valid,
    input  logic [ID_W-1:0]          done_id,
    input  logic [1:0]               done_resp,
    output logic                     done_ready,
    axi4b_if.slave                   b_if,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_seen
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            bvalid_q, bvalid_d;
    logic [ID_W-1:0] bid_q, bid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic            rdy_q;

    logic            accept, xfer, push, pop, fifo_empty;
    b_entry_t        din, head;
    logic [$bits(b_entry_t)-1:0] head_raw;
    logic [ID_MAX_W-1:0]         head_id_unused;

    assign din            = '{id: ID_MAX_W'(done_id), resp: resp_e'(done_resp)};
    assign head           = b_entry_t'(head_raw);
    assign head_id_unused = head.id;

    axi4b_resp_fifo #(.N(DEPTH - 1), .W($bits(b_entry_t))) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (din),
        .pop_i   (pop),
        .rdata_o (head_raw),
        .empty_o (fifo_empty)
    );

    always_comb begin
        accept   = done_valid && rdy_q;
        xfer     = bvalid_q && b_if.bready;
        pop      = xfer && !fifo_empty;
        // Queue is bypassed whenever the output register is (or is becoming) free with nothing ahead.
        push     = accept && bvalid_q && !(xfer && fifo_empty);
        bvalid_d = bvalid_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        if (pop) begin
            bvalid_d = 1'b1;
            bid_d    = head.id[ID_W-1:0];
            bresp_d  = head.resp;
        end else if (accept && (!bvalid_q || xfer)) begin
            bvalid_d = 1'b1;
            bid_d    = done_id;
            bresp_d  = done_resp;
        end else if (xfer) begin
            bvalid_d = 1'b0;
        end
        count_d = count_q + CW'(accept) - CW'(xfer);
        err_d   = err_q || (xfer && resp_is_err(bresp_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            bvalid_q <= bvalid_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
            count_q  <= count_d;
            err_q    <= err_d;
            rdy_q    <= (count_d < CW'(DEPTH));
        end
    end

    assign b_if.bvalid = bvalid_q;
    assign b_if.bid    = bid_q;
    assign b_if.bresp  = bresp_q;
    assign done_ready  = rdy_q;
    assign count       = count_q;
    assign err_seen    = err_q;

endmodule
